// File: rtl/cache_axi_arbiter_if.sv
// Signal bundle between the two caches, the arbiter and the AXI3 slave.
// The master modport is the arbiter; the slave modport is everything around it
// (both caches plus the AXI slave).
//
// Handshake rule used on every AXI channel: a transfer happens on a rising
// clock edge where valid and ready are both 1; once raised, valid and its
// payload stay unchanged until that edge, and ready never waits on anything
// the other side has not yet driven.
interface cache_axi_arbiter_if;
   // instruction cache side
   logic        inst_cache_req;
   logic [31:0] inst_cache_addr;
   logic [31:0] inst_cache_rdata;
   logic        inst_cache_dok;
   // data cache side
   logic        data_cache_rreq;
   logic        data_cache_wreq;
   logic [31:0] data_cache_addr;
   logic [31:0] data_cache_wdata;
   logic [3:0]  data_cache_wstrb;
   logic [31:0] data_cache_rdata;
   logic        data_cache_rdok;
   logic        data_cache_wdok;
   // AXI read address
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   // AXI read data
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   // AXI write address
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   // AXI write data
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   // AXI write response
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      input  inst_cache_req, inst_cache_addr,
      output inst_cache_rdata, inst_cache_dok,
      input  data_cache_rreq, data_cache_wreq, data_cache_addr,
      input  data_cache_wdata, data_cache_wstrb,
      output data_cache_rdata, data_cache_rdok, data_cache_wdok,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      output inst_cache_req, inst_cache_addr,
      input  inst_cache_rdata, inst_cache_dok,
      output data_cache_rreq, data_cache_wreq, data_cache_addr,
      output data_cache_wdata, data_cache_wstrb,
      input  data_cache_rdata, data_cache_rdok, data_cache_wdok,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/cache_axi_arbiter.sv
// Single-outstanding AXI3 bridge for the instruction cache and the
// write-through data cache. Stores beat data reads, data reads beat
// instruction reads; every transaction is one beat and the winner gets a
// one-cycle done pulse. The FSM state is exported on dbg_state.
module cache_axi_arbiter #(
   parameter logic [3:0] INST_ID = 4'd0,
   parameter logic [3:0] DATA_ID = 4'd1
) (
   input  logic                       clk,
   input  logic                       resetn,
   cache_axi_arbiter_if.master        bus,
   output logic [2:0]                 dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AR   = 3'd1,
      S_R    = 3'd2,
      S_AW_W = 3'd3,
      S_B    = 3'd4,
      S_DONE = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      SRC_INST   = 2'd0,
      SRC_DREAD  = 2'd1,
      SRC_DWRITE = 2'd2
   } src_e;

   state_e      state_q, state_d;
   src_e        src_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [31:0] inst_rdata_q;
   logic [31:0] data_rdata_q;
   logic        aw_done_q;
   logic        w_done_q;
   logic        aw_hs;
   logic        w_hs;

   // Response fields that carry nothing this single-beat bridge needs.
   logic unused_resp;
   assign unused_resp = ^{bus.rid, bus.rresp, bus.rlast, bus.bid, bus.bresp};

   assign aw_hs     = bus.awvalid & bus.awready;
   assign w_hs      = bus.wvalid  & bus.wready;
   assign dbg_state = state_q;

   // Burst attributes never change: one 32-bit INCR beat, normal access.
   assign bus.arlen   = 4'd0;
   assign bus.arsize  = 3'b010;
   assign bus.arburst = 2'b01;
   assign bus.arlock  = 2'd0;
   assign bus.arcache = 4'd0;
   assign bus.arprot  = 3'd0;
   assign bus.awlen   = 4'd0;
   assign bus.awsize  = 3'b010;
   assign bus.awburst = 2'b01;
   assign bus.awlock  = 2'd0;
   assign bus.awcache = 4'd0;
   assign bus.awprot  = 3'd0;

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state: arbitrate in IDLE, then follow the AXI handshakes.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.data_cache_wreq)                          state_d = S_AW_W;
            else if (bus.data_cache_rreq || bus.inst_cache_req) state_d = S_AR;
         end
         S_AR:   if (bus.arready) state_d = S_R;
         S_R:    if (bus.rvalid)  state_d = S_DONE;
         S_AW_W: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_B;
         S_B:    if (bus.bvalid)  state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request latch, per-channel write flags and read data capture.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         src_q        <= SRC_INST;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         wstrb_q      <= 4'd0;
         inst_rdata_q <= 32'd0;
         data_rdata_q <= 32'd0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
      end else begin
         if (state_q == S_IDLE) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (bus.data_cache_wreq) begin
               src_q   <= SRC_DWRITE;
               addr_q  <= bus.data_cache_addr;
               wdata_q <= bus.data_cache_wdata;
               wstrb_q <= bus.data_cache_wstrb;
            end else if (bus.data_cache_rreq) begin
               src_q  <= SRC_DREAD;
               addr_q <= bus.data_cache_addr;
            end else if (bus.inst_cache_req) begin
               src_q  <= SRC_INST;
               addr_q <= bus.inst_cache_addr;
            end
         end
         if (state_q == S_AW_W) begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
         end
         if (state_q == S_R && bus.rvalid) begin
            if (src_q == SRC_INST) inst_rdata_q <= bus.rdata;
            else                   data_rdata_q <= bus.rdata;
         end
      end
   end

   // Outputs decoded from registered state only; no request input reaches AXI.
   always_comb begin
      bus.arid             = (src_q == SRC_INST) ? INST_ID : DATA_ID;
      bus.araddr           = addr_q;
      bus.arvalid          = (state_q == S_AR);
      bus.rready           = (state_q == S_R);
      bus.awid             = DATA_ID;
      bus.awaddr           = addr_q;
      bus.awvalid          = (state_q == S_AW_W) && !aw_done_q;
      bus.wid              = DATA_ID;
      bus.wdata            = wdata_q;
      bus.wstrb            = wstrb_q;
      bus.wlast            = 1'b1;
      bus.wvalid           = (state_q == S_AW_W) && !w_done_q;
      bus.bready           = (state_q == S_B);
      bus.inst_cache_rdata = inst_rdata_q;
      bus.data_cache_rdata = data_rdata_q;
      bus.inst_cache_dok   = (state_q == S_DONE) && (src_q == SRC_INST);
      bus.data_cache_rdok  = (state_q == S_DONE) && (src_q == SRC_DREAD);
      bus.data_cache_wdok  = (state_q == S_DONE) && (src_q == SRC_DWRITE);
   end

endmodule

// File: doc/cache_axi_arbiter.md
# cache_axi_arbiter

Bus-side responder for the instruction cache and the write-through data cache. It accepts single-word miss reads from both caches and write-through stores from the data cache, arbitrates between them, and runs each as a single-beat AXI3 transaction. It returns read data with a one-cycle done pulse. Exactly one transaction is in flight at a time.

## Interface
- `INST_ID`, 4'd0: `arid` used for instruction reads.
- `DATA_ID`, 4'd1: `arid`/`awid`/`wid` used for data accesses.
- `clk`  in  1  system clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `inst_cache_req`  in  1  instruction miss read request (level); held until `inst_cache_dok`.
- `inst_cache_addr`  in  32  instruction read address; stable while req is high.
- `inst_cache_rdata`  out  32  read word; valid in the `inst_cache_dok` cycle and held until the next inst read completes.
- `inst_cache_dok`  out  1  one-cycle pulse: instruction read complete.
- `data_cache_rreq`  in  1  data miss read request (level).
- `data_cache_wreq`  in  1  write-through store request (level); never high together with rreq.
- `data_cache_addr`  in  32  data access address.
- `data_cache_wdata`  in  32  store data.
- `data_cache_wstrb`  in  4  store byte enables.
- `data_cache_rdata`  out  32  read word; held until the next data read completes.
- `data_cache_rdok`  out  1  one-cycle pulse: data read complete.
- `data_cache_wdok`  out  1  one-cycle pulse: store acknowledged (B received).
- `arid`/`araddr`/`arvalid`  out  4/32/1  AXI read address; `arready` in 1.
- `rid`/`rdata`/`rresp`/`rlast`/`rvalid`  in  4/32/2/1/1  AXI read data; `rready` out 1.
- `awid`/`awaddr`/`awvalid`  out  4/32/1  AXI write address; `awready` in 1.
- `wid`/`wdata`/`wstrb`/`wlast`/`wvalid`  out  4/32/4/1/1  AXI write data; `wready` in 1.
- `bid`/`bresp`/`bvalid`  in  4/2/1  AXI write response; `bready` out 1.
- Constant outputs: `arlen`/`awlen` = 0, `arsize`/`awsize` = 3'b010, `arburst`/`awburst` = 2'b01, `arlock`/`awlock` = 0, `arcache`/`awcache` = 0, `arprot`/`awprot` = 0.

## Operation
- States: IDLE, AR, R, AW_W, B, DONE.
- IDLE arbitration, highest priority first: `data_cache_wreq`, then `data_cache_rreq`, then `inst_cache_req`.
  - Latch the winner (source, addr, wdata, wstrb). Select ID from source.
  - Reads go to AR; stores go to AW_W.
- AR: `arvalid=1` with the latched addr and ID. On `arready` go to R.
- R: `rready=1`. On `rvalid`:
  - Capture `rdata` into the winner's rdata register.
  - Go to DONE.
  - `rresp` and `rid` are ignored; `rlast` is expected to be 1.
- AW_W: assert `awvalid` and `wvalid` (`wlast=1`) together.
  - Per-channel flags `aw_done`/`w_done` set on their handshakes; each valid drops after its own handshake.
  - Go to B once both are done; handshakes in the same cycle or in either order are accepted.
- B: `bready=1`; on `bvalid` go to DONE. `bresp` is ignored.
- DONE: pulse the winner's dok (`inst_cache_dok`, `data_cache_rdok` or `data_cache_wdok`) for exactly one cycle, then go to IDLE.
  - Requests are not sampled in DONE, so a request still high while the cache updates is not re-issued.
- All AXI valids and readies are registered from state; no combinational path from request inputs to AXI outputs.
- Reset state: state = IDLE. All valids/readies = 0; all dok = 0; both rdata registers = 0; `araddr`/`awaddr`/`wdata` = 0; `wstrb` = 0; `aw_done`/`w_done` = 0.
- Reset mid-transaction: return to IDLE immediately with all outputs at reset values. An AXI handshake in progress is abandoned; the slave is reset on the same `resetn`.

## Timing
- Read, req high at IDLE in cycle t:
  - `arvalid` high in t+1.
  - With `arready=1` in t+1, `rready` high in t+2.
  - With `rvalid` in t+2, dok and rdata are valid in t+3.
  - IDLE in t+4. Minimum req→dok latency is 3 cycles.
- Store: `awvalid`/`wvalid` in t+1; `bready` from t+2 at earliest; `wdok` one cycle after the `bvalid` handshake. Minimum latency is 3 cycles.
- Back-to-back: the next request is accepted in the IDLE cycle after DONE. Minimum spacing between dok pulses is 4 cycles.
- Simultaneous inst and data requests: data is served first; inst waits in IDLE arbitration with no starvation bound.
- Each valid is held until its handshake; address and data are stable while valid is high.

## Test plan
- Inst read, slave with `arready=1` and `rvalid` one cycle after AR, `inst_cache_addr=0xBFC00000`, `rdata=0x3C1D8000` -> `araddr=0xBFC00000`, `arid=0`, `inst_cache_dok` for 1 cycle at t+3 with rdata 0x3C1D8000; `data_cache_rdok` stays 0.
- Inst and data read requests in the same cycle -> data read issued first with `arid=1`; inst AR issued in the cycle after the data DONE+IDLE. Two dok pulses, 4 or more cycles apart, each with the correct rdata.
- Store `addr=0x80001004`, `wdata=0xDEADBEEF`, `wstrb=4'b0011`; `wready` 3 cycles after `awready` -> `awvalid` drops after its handshake and `wvalid` stays high until its handshake; `wdok` pulses 1 cycle after `bvalid`.
- Store with `awready`/`wready` in the same cycle, `bvalid` delayed 5 cycles -> `bready` held for 5 cycles; exactly one `wdok`.
- `arready` low for 4 cycles -> `arvalid` and `araddr` stable for all 4 cycles; `inst_cache_rdata` still shows the previous value until the new dok.
- Assert `resetn=0` during R state -> asynchronously: `rready=0`, `arvalid=0`, all dok=0, state IDLE. After release, a pending request restarts from AR.
